// File: rtl/pipe_buffer_chain.sv
// Parametrised chain of pipeline buffer stages with per-stage stall/flush,
// automatic bubble insertion, hazard/forwarding lookup and a stall-cycle counter.
module pipe_buffer_chain #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 4,
  parameter int STAGES = 4,
  parameter int NQ     = 2,
  parameter int CNT_W  = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic                               in_wr,
  input  logic [ADDR_W-1:0]                  in_rd,
  input  logic [DATA_W-1:0]                  in_data,
  output logic                               in_ready,
  input  logic [STAGES-1:0]                  stall_req,
  input  logic [STAGES-1:0]                  flush_mask,
  input  logic                               flush_in,
  output logic                               out_valid,
  output logic                               out_wr,
  output logic [ADDR_W-1:0]                  out_rd,
  output logic [DATA_W-1:0]                  out_data,
  output logic [STAGES-1:0]                  stage_valid,
  output logic [$clog2(STAGES+1)-1:0]        occupancy,
  input  logic [NQ*ADDR_W-1:0]               q_addr,
  output logic [NQ-1:0]                      q_hit,
  output logic [NQ*$clog2(STAGES)-1:0]       q_sel,
  output logic [CNT_W-1:0]                   stall_cycles
);

  localparam int OCC_W = $clog2(STAGES + 1);
  localparam int SEL_W = $clog2(STAGES);

  logic [STAGES-1:0] validR;
  logic [STAGES-1:0] wrR;
  logic [ADDR_W-1:0] rdR   [STAGES];
  logic [DATA_W-1:0] dataR [STAGES];
  logic [STAGES-1:0] effValid;
  logic [STAGES-1:0] hold;
  logic [CNT_W-1:0]  stallCnt;

  assign effValid = validR & ~flush_mask;

  // A stalled stage freezes every stage upstream of it.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc     = acc | stall_req[i];
      hold[i] = acc;
    end
  end

  // Handshake: an entry transfers on an edge where in_valid and in_ready are
  // both high; in_ready depends only on the stall state, never on in_valid.
  assign in_ready = ~hold[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      validR <= '0;
      wrR    <= '0;
      for (int i = 0; i < STAGES; i++) begin
        rdR[i]   <= '0;
        dataR[i] <= '0;
      end
    end else begin
      if (hold[0]) begin
        validR[0] <= effValid[0];
      end else begin
        validR[0] <= in_valid & ~flush_in;
        wrR[0]    <= in_wr;
        rdR[0]    <= in_rd;
        dataR[0]  <= in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (hold[i]) begin
          validR[i] <= effValid[i];
        end else if (hold[i-1]) begin
          // Upstream is frozen: pass a bubble, payload left as is.
          validR[i] <= 1'b0;
        end else begin
          validR[i] <= effValid[i-1];
          wrR[i]    <= wrR[i-1];
          rdR[i]    <= rdR[i-1];
          dataR[i]  <= dataR[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stallCnt <= '0;
    end else if (in_valid && !in_ready && stallCnt != {CNT_W{1'b1}}) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(effValid[i]);
    end
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    q_hit = '0;
    q_sel = '0;
    for (int k = 0; k < NQ; k++) begin
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (effValid[i] && wrR[i] && (rdR[i] == q_addr[k*ADDR_W +: ADDR_W])) begin
          q_hit[k]                 = 1'b1;
          q_sel[k*SEL_W +: SEL_W]  = SEL_W'(i);
        end
      end
    end
  end

  assign stage_valid  = effValid;
  assign out_valid    = effValid[STAGES-1];
  assign out_wr       = wrR[STAGES-1];
  assign out_rd       = rdR[STAGES-1];
  assign out_data     = dataR[STAGES-1];
  assign stall_cycles = stallCnt;

endmodule
